// File: rtl/dcache_pkg.sv
// Shared types and geometry for the data-cache miss/writeback sequencer.
package dcache_pkg;

    localparam int ADDR_W      = 32;
    localparam int WORD_W      = 32;
    localparam int BLOCK_W     = 512;
    localparam int OFFSET_BITS = 4;
    localparam int INDEX_BITS  = 8;
    localparam int TAG_BITS    = ADDR_W - OFFSET_BITS - INDEX_BITS;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        WB     = 3'd2,
        FETCH  = 3'd3,
        FILL   = 3'd4,
        RESP   = 3'd5
    } state_e;

    typedef struct packed {
        state_e state;
        logic   replay;
        logic   lookup_miss;
    } dbg_t;

    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_BITS-1:0]   tag,
                                                     input logic [INDEX_BITS-1:0] index);
        return {tag, index, {OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_mem_port.sv
// Memory-side request register: one line transfer at a time, request drops on the ack edge.
module dcache_mem_port
    import dcache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               we_i,
    input  logic [ADDR_W-1:0]  addr_i,
    input  logic [BLOCK_W-1:0] wdata_i,
    input  logic               mem_ack_i,
    input  logic [BLOCK_W-1:0] mem_rdata_i,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [BLOCK_W-1:0] mem_wdata_o,
    output logic               done_o,
    output logic [BLOCK_W-1:0] fill_o
);

    logic               req_q;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [BLOCK_W-1:0] wdata_q;
    logic [BLOCK_W-1:0] fill_q;

    // An ack only counts while a request is outstanding.
    assign done_o = req_q & mem_ack_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            fill_q  <= '0;
        end else if (start_i) begin
            req_q  <= 1'b1;
            we_q   <= we_i;
            addr_q <= addr_i;
            if (we_i) begin
                wdata_q <= wdata_i;
            end
        end else if (done_o) begin
            req_q <= 1'b0;
            if (!we_q) begin
                fill_q <= mem_rdata_i;
            end
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign fill_o      = fill_q;

endmodule

// File: rtl/dcache_ctrl.sv
// Miss/writeback sequencer for the direct-mapped data cache.
// Optional hit/miss/writeback counters are built when DCACHE_PERF_CNT_EN is defined.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req_i,
    input  logic                cpu_rd_i,
    input  logic                cpu_wr_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [WORD_W-1:0]   cpu_wdata_i,
    output logic [WORD_W-1:0]   cpu_rdata_o,
    output logic                cpu_done_o,
    output logic                cpu_busy_o,
    output logic                cache_en_o,
    output logic                cache_rd_o,
    output logic                cache_wr_o,
    output logic                cache_ld_o,
    output logic [ADDR_W-1:0]   cache_addr_o,
    output logic [WORD_W-1:0]   cache_din_o,
    output logic [BLOCK_W-1:0]  cache_blkin_o,
    input  logic [WORD_W-1:0]   cache_dout_i,
    input  logic                cache_hit_i,
    input  logic                cache_miss_i,
    input  logic                cache_evict_i,
    input  logic [BLOCK_W-1:0]  cache_blkout_i,
    input  logic [TAG_BITS-1:0] cache_victim_tag_i,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [BLOCK_W-1:0]  mem_wdata_o,
    input  logic                mem_ack_i,
    input  logic [BLOCK_W-1:0]  mem_rdata_i,
`ifdef DCACHE_PERF_CNT_EN
    output logic [31:0]         perf_hits_o,
    output logic [31:0]         perf_misses_o,
    output logic [31:0]         perf_wbs_o,
`endif
    output dbg_t                dbg_o
);

    state_e            state_q, state_d;
    logic              op_rd_q;
    logic              replay_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] rdata_q;
    logic              done_q;
    logic              busy_q;

    logic              mp_start, mp_we, mp_done;
    logic [ADDR_W-1:0] mp_addr;

    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  accept;

    assign req_index = addr_q[OFFSET_BITS +: INDEX_BITS];
    assign req_tag   = addr_q[ADDR_W-1 -: TAG_BITS];
    assign accept    = cpu_req_i & (cpu_rd_i ^ cpu_wr_i);

    always_comb begin
        state_d  = state_q;
        mp_start = 1'b0;
        mp_we    = 1'b0;
        mp_addr  = line_addr(req_tag, req_index);
        case (state_q)
            IDLE:   if (accept) state_d = LOOKUP;
            LOOKUP: begin
                if (cache_hit_i) begin
                    state_d = RESP;
                end else begin
                    mp_start = 1'b1;
                    if (cache_evict_i) begin
                        mp_we   = 1'b1;
                        mp_addr = line_addr(cache_victim_tag_i, req_index);
                        state_d = WB;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            WB:     if (mp_done) state_d = FETCH;
            // Entered from WB with the request low: raise the read one edge later.
            FETCH: begin
                if (!mem_req_o) begin
                    mp_start = 1'b1;
                end else if (mp_done) begin
                    state_d = FILL;
                end
            end
            FILL:   state_d = LOOKUP;
            RESP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_rd_q  <= 1'b0;
            replay_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == LOOKUP) && cache_hit_i;
            busy_q  <= (state_d != IDLE);
            if (state_q == IDLE && accept) begin
                addr_q   <= cpu_addr_i;
                wdata_q  <= cpu_wdata_i;
                op_rd_q  <= cpu_rd_i;
                replay_q <= 1'b0;
            end
            if (state_q == FILL) begin
                replay_q <= 1'b1;
            end
            if (state_q == LOOKUP && cache_hit_i && op_rd_q) begin
                rdata_q <= cache_dout_i;
            end
        end
    end

    dcache_mem_port u_mem_port (
        .clk         (clk),
        .rst         (rst),
        .start_i     (mp_start),
        .we_i        (mp_we),
        .addr_i      (mp_addr),
        .wdata_i     (cache_blkout_i),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .done_o      (mp_done),
        .fill_o      (cache_blkin_o)
    );

    assign cache_en_o   = (state_q == LOOKUP) || (state_q == FILL);
    assign cache_rd_o   = (state_q == LOOKUP) && op_rd_q;
    assign cache_wr_o   = (state_q == LOOKUP) && !op_rd_q;
    assign cache_ld_o   = (state_q == FILL);
    assign cache_addr_o = addr_q;
    assign cache_din_o  = wdata_q;

    assign cpu_rdata_o = rdata_q;
    assign cpu_done_o  = done_q;
    assign cpu_busy_o  = busy_q;

    assign dbg_o = '{state: state_q, replay: replay_q,
                     lookup_miss: (state_q == LOOKUP) && cache_miss_i};

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hits_q, misses_q, wbs_q;
    logic        first_lookup;

    // Replays after a fill always hit and are excluded from the counts.
    assign first_lookup = (state_q == LOOKUP) && !replay_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hits_q   <= '0;
            misses_q <= '0;
            wbs_q    <= '0;
        end else if (first_lookup) begin
            if (cache_hit_i) begin
                hits_q <= hits_q + 32'd1;
            end else begin
                misses_q <= misses_q + 32'd1;
                if (cache_evict_i) begin
                    wbs_q <= wbs_q + 32'd1;
                end
            end
        end
    end

    assign perf_hits_o   = hits_q;
    assign perf_misses_o = misses_q;
    assign perf_wbs_o    = wbs_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a behavioural direct-mapped cache and a hand-driven memory port.
module tb_dcache_ctrl;
    import dcache_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                cpu_req, cpu_rd, cpu_wr;
    logic [ADDR_W-1:0]   cpu_addr;
    logic [WORD_W-1:0]   cpu_wdata, cpu_rdata;
    logic                cpu_done, cpu_busy;
    logic                cache_en, cache_rd, cache_wr, cache_ld;
    logic [ADDR_W-1:0]   cache_addr;
    logic [WORD_W-1:0]   cache_din, cache_dout;
    logic [BLOCK_W-1:0]  cache_blkin, cache_blkout;
    logic                cache_hit, cache_miss, cache_evict;
    logic [TAG_BITS-1:0] cache_victim_tag;
    logic                mem_req, mem_we, mem_ack;
    logic [ADDR_W-1:0]   mem_addr;
    logic [BLOCK_W-1:0]  mem_wdata, mem_rdata;
    dbg_t                dbg;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0]         perf_hits, perf_misses, perf_wbs;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int ld_cnt   = 0;
    int done_cnt = 0;
    int req_cnt  = 0;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .cpu_req_i          (cpu_req),
        .cpu_rd_i           (cpu_rd),
        .cpu_wr_i           (cpu_wr),
        .cpu_addr_i         (cpu_addr),
        .cpu_wdata_i        (cpu_wdata),
        .cpu_rdata_o        (cpu_rdata),
        .cpu_done_o         (cpu_done),
        .cpu_busy_o         (cpu_busy),
        .cache_en_o         (cache_en),
        .cache_rd_o         (cache_rd),
        .cache_wr_o         (cache_wr),
        .cache_ld_o         (cache_ld),
        .cache_addr_o       (cache_addr),
        .cache_din_o        (cache_din),
        .cache_blkin_o      (cache_blkin),
        .cache_dout_i       (cache_dout),
        .cache_hit_i        (cache_hit),
        .cache_miss_i       (cache_miss),
        .cache_evict_i      (cache_evict),
        .cache_blkout_i     (cache_blkout),
        .cache_victim_tag_i (cache_victim_tag),
        .mem_req_o          (mem_req),
        .mem_we_o           (mem_we),
        .mem_addr_o         (mem_addr),
        .mem_wdata_o        (mem_wdata),
        .mem_ack_i          (mem_ack),
        .mem_rdata_i        (mem_rdata),
`ifdef DCACHE_PERF_CNT_EN
        .perf_hits_o        (perf_hits),
        .perf_misses_o      (perf_misses),
        .perf_wbs_o         (perf_wbs),
`endif
        .dbg_o              (dbg)
    );

    // Behavioural cache: contents survive controller reset.
    logic [BLOCK_W-1:0]  c_data  [256];
    logic [TAG_BITS-1:0] c_tag   [256];
    logic                c_valid [256] = '{default: 1'b0};
    logic                c_dirty [256] = '{default: 1'b0};
    logic [7:0]          c_idx;
    logic [3:0]          c_off;
    logic                c_match;

    assign c_idx            = cache_addr[11:4];
    assign c_off            = cache_addr[3:0];
    assign c_match          = c_valid[c_idx] && (c_tag[c_idx] == cache_addr[31:12]);
    assign cache_hit        = cache_en && c_match;
    assign cache_miss       = cache_en && !c_match;
    assign cache_evict      = cache_en && !c_match && c_valid[c_idx] && c_dirty[c_idx];
    assign cache_dout       = c_data[c_idx][c_off*32 +: 32];
    assign cache_blkout     = c_data[c_idx];
    assign cache_victim_tag = c_tag[c_idx];

    always @(posedge clk) begin
        if (cache_en && cache_wr && c_match) begin
            c_data[c_idx][c_off*32 +: 32] <= cache_din;
            c_dirty[c_idx] <= 1'b1;
        end
        if (cache_en && cache_ld) begin
            c_data[c_idx]  <= cache_blkin;
            c_tag[c_idx]   <= cache_addr[31:12];
            c_valid[c_idx] <= 1'b1;
            c_dirty[c_idx] <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (cache_ld) ld_cnt <= ld_cnt + 1;
        if (cpu_done) done_cnt <= done_cnt + 1;
        if (mem_req) req_cnt <= req_cnt + 1;
    end

    function automatic logic [BLOCK_W-1:0] mk_line(input logic [31:0] w4);
        logic [BLOCK_W-1:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = 32'h0BAD_0000 + i;
        l[4*32 +: 32] = w4;
        return l;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [BLOCK_W-1:0] obs, input logic [BLOCK_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        cpu_req = 1'b1; cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    endtask

    task automatic wait_done(input string tag, input int max, output int cyc);
        cyc = 0;
        while (cyc < max) begin
            tick();
            cyc++;
            if (cpu_done) break;
        end
        chk({tag, "_done"}, BLOCK_W'(cpu_done), BLOCK_W'(1));
        cpu_req = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    endtask

    task automatic wait_mem_req(input string tag, input int max);
        int n = 0;
        while (!mem_req && n < max) begin
            tick();
            n++;
        end
        chk(tag, BLOCK_W'(mem_req), BLOCK_W'(1));
    endtask

    task automatic ack_pulse(input logic [BLOCK_W-1:0] line);
        mem_ack = 1'b1; mem_rdata = line;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
    endtask

    initial begin
        int cyc, ld0, d0, r0;
        rst = 1'b1;
        cpu_req = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) tick();

        chk("rst_done",  BLOCK_W'(cpu_done),  '0);
        chk("rst_busy",  BLOCK_W'(cpu_busy),  '0);
        chk("rst_req",   BLOCK_W'(mem_req),   '0);
        chk("rst_we",    BLOCK_W'(mem_we),    '0);
        chk("rst_addr",  BLOCK_W'(mem_addr),  '0);
        chk("rst_wdata", mem_wdata,           '0);
        chk("rst_rdata", BLOCK_W'(cpu_rdata), '0);
        chk("rst_strb",  BLOCK_W'({cache_en, cache_rd, cache_wr, cache_ld}), '0);
        rst = 1'b0;
        tick();

        // Read miss on an empty cache.
        issue(1'b1, 1'b0, 32'h0000_1234, '0);
        tick();
        chk("a_busy",  BLOCK_W'(cpu_busy), BLOCK_W'(1));
        chk("a_lkup",  BLOCK_W'({cache_en, cache_rd, cache_wr}), BLOCK_W'(3'b110));
        chk("a_caddr", BLOCK_W'(cache_addr), BLOCK_W'(32'h1234));
        wait_mem_req("a_req", 10);
        chk("a_we",   BLOCK_W'(mem_we),   '0);
        chk("a_addr", BLOCK_W'(mem_addr), BLOCK_W'(32'h1230));
        ld0 = ld_cnt;
        repeat (3) tick();
        chk("a_hold", BLOCK_W'(mem_req), BLOCK_W'(1));
        ack_pulse(mk_line(32'hDEAD_BEEF));
        wait_done("a", 20, cyc);
        chk("a_rdata", BLOCK_W'(cpu_rdata), BLOCK_W'(32'hDEAD_BEEF));
        chk("a_ld",    BLOCK_W'(ld_cnt - ld0), BLOCK_W'(1));
        tick();
        chk("a_idle", BLOCK_W'(cpu_busy), '0);

        // Repeat read hits in 2 cycles without touching memory.
        r0 = req_cnt;
        issue(1'b1, 1'b0, 32'h0000_1234, '0);
        wait_done("b", 10, cyc);
        chk("b_lat",   BLOCK_W'(cyc), BLOCK_W'(2));
        chk("b_rdata", BLOCK_W'(cpu_rdata), BLOCK_W'(32'hDEAD_BEEF));
        chk("b_noreq", BLOCK_W'(req_cnt - r0), '0);
        tick();

        // Write hit, then a conflicting read forces a writeback.
        issue(1'b0, 1'b1, 32'h0000_1234, 32'hCAFE_F00D);
        wait_done("c_wr", 10, cyc);
        chk("c_wr_lat", BLOCK_W'(cyc), BLOCK_W'(2));
        tick();
        issue(1'b1, 1'b0, 32'h0000_2234, '0);
        wait_mem_req("c_wbreq", 10);
        chk("c_we",    BLOCK_W'(mem_we),   BLOCK_W'(1));
        chk("c_addr",  BLOCK_W'(mem_addr), BLOCK_W'(32'h1230));
        chk("c_word4", BLOCK_W'(mem_wdata[159:128]), BLOCK_W'(32'hCAFE_F00D));
        d0 = done_cnt;
        repeat (10) begin
            tick();
            chk("d_req",   BLOCK_W'(mem_req),  BLOCK_W'(1));
            chk("d_addr",  BLOCK_W'(mem_addr), BLOCK_W'(32'h1230));
            chk("d_wdata", mem_wdata,          mk_line(32'hCAFE_F00D));
            chk("d_busy",  BLOCK_W'(cpu_busy), BLOCK_W'(1));
        end
        chk("d_nodone", BLOCK_W'(done_cnt - d0), '0);
        ack_pulse(mk_line(32'h0));
        chk("c_gap", BLOCK_W'(mem_req), '0);
        tick();
        chk("c_freq",  BLOCK_W'(mem_req),  BLOCK_W'(1));
        chk("c_fwe",   BLOCK_W'(mem_we),   '0);
        chk("c_faddr", BLOCK_W'(mem_addr), BLOCK_W'(32'h2230));
        ack_pulse(mk_line(32'h1111_2222));
        wait_done("c_rd", 20, cyc);
        chk("c_rdata", BLOCK_W'(cpu_rdata), BLOCK_W'(32'h1111_2222));
        tick();

        // Reset while a fetch is outstanding.
        issue(1'b1, 1'b0, 32'h0000_1234, '0);
        wait_mem_req("e_req", 10);
        chk("e_addr", BLOCK_W'(mem_addr), BLOCK_W'(32'h1230));
        chk("e_we",   BLOCK_W'(mem_we),   '0);
        tick();
        ld0 = ld_cnt;
        d0  = done_cnt;
        #2 rst = 1'b1;
        #1;
        chk("e_rst_req",  BLOCK_W'(mem_req),  '0);
        chk("e_rst_busy", BLOCK_W'(cpu_busy), '0);
        chk("e_rst_done", BLOCK_W'(cpu_done), '0);
        cpu_req = 1'b0; cpu_rd = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("e_no_ld",   BLOCK_W'(ld_cnt - ld0),   '0);
        chk("e_no_done", BLOCK_W'(done_cnt - d0),  '0);
        issue(1'b1, 1'b0, 32'h0000_1234, '0);
        wait_mem_req("e2_req", 10);
        chk("e2_addr", BLOCK_W'(mem_addr), BLOCK_W'(32'h1230));
        ack_pulse(mk_line(32'hCAFE_F00D));
        wait_done("e2", 20, cyc);
        chk("e2_rdata", BLOCK_W'(cpu_rdata), BLOCK_W'(32'hCAFE_F00D));
        tick();

        // Ambiguous request (rd and wr both set) is ignored.
        d0 = done_cnt;
        issue(1'b1, 1'b1, 32'h0000_1234, 32'h5555_AAAA);
        repeat (3) begin
            tick();
            chk("f_busy", BLOCK_W'(cpu_busy), '0);
            chk("f_strb", BLOCK_W'({cache_en, cache_rd, cache_wr, cache_ld}), '0);
            chk("f_req",  BLOCK_W'(mem_req), '0);
        end
        chk("f_nodone", BLOCK_W'(done_cnt - d0), '0);
        cpu_req = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Miss/writeback sequencer between the core load/store port and the 32-bit-word, 512-bit-line direct-mapped data cache.
- Accepts one CPU access at a time and performs the tag lookup.
- On a dirty miss it writes the victim line back to memory, then fetches and loads the new line.
- Replays the access so it completes as a hit.

Parameters:
- ADDR_W, 32, CPU word address width.
- BLOCK_W, 512, cache line / memory transfer width.
- WORD_W, 32, data word width.
- OFFSET_BITS, 4, word-offset bits (16 words per line).
- INDEX_BITS, 8, line index bits (256 lines).
- TAG_BITS, 20, equal to ADDR_W-OFFSET_BITS-INDEX_BITS.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cpu_req  in  1  access request; held until cpu_done.
- cpu_rd  in  1  read access.
- cpu_wr  in  1  write access.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  WORD_W  write data.
- cpu_rdata  out  WORD_W  read data; valid while cpu_done=1.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_busy  out  1  high whenever state != IDLE.
- cache_en  out  1  cache enable.
- cache_rd  out  1  cache read strobe.
- cache_wr  out  1  cache write strobe.
- cache_ld  out  1  cache line-load strobe.
- cache_addr  out  ADDR_W  cache address.
- cache_din  out  WORD_W  write word to cache.
- cache_blkin  out  BLOCK_W  fill line to cache.
- cache_dout  in  WORD_W  cache read word.
- cache_hit  in  1  cache hit.
- cache_miss  in  1  cache miss.
- cache_evict  in  1  cache evict indication.
- cache_blkout  in  BLOCK_W  victim line.
- cache_victim_tag  in  TAG_BITS  stored tag of the indexed line.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = line write, 0 = line read.
- mem_addr  out  ADDR_W  line address, with the low OFFSET_BITS bits always 0.
- mem_wdata  out  BLOCK_W  writeback line.
- mem_ack  in  1  one-cycle acknowledge.
- mem_rdata  in  BLOCK_W  fill line; valid while mem_ack=1.

Behaviour:
- Reset (async): state IDLE, all registered outputs 0 (cpu_done, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata, request and line buffers); cache_* strobes 0. Cache contents are untouched.
- Cache strobes are decoded combinationally from state and the latched request; all other outputs are registered.
- IDLE:
  - cpu_req with exactly one of cpu_rd/cpu_wr set: latch addr, wdata and op; go to LOOKUP.
  - cpu_req with rd==wr: ignored; no state change, no done pulse.
- LOOKUP: cache_en=1, cache_addr=latched addr, cache_rd or cache_wr per op, cache_din=latched wdata.
  - Hit: read captures cache_dout into cpu_rdata; write lands in the cache at this edge. Next state is RESP.
  - Miss with cache_evict: capture cache_blkout into mem_wdata; mem_addr={cache_victim_tag, index, 0}; mem_we=1; mem_req=1; go to WB.
  - Miss without evict (clean or invalid line): mem_addr={tag, index, 0}; mem_we=0; mem_req=1; go to FETCH.
- WB: hold mem_req, mem_addr and mem_wdata stable until mem_ack. On mem_ack clear mem_req; go to FETCH, which raises a read request on the next edge. mem_req is therefore low for at least one cycle between transfers.
- FETCH: hold the read request until mem_ack; capture mem_rdata into the fill buffer; clear mem_req; go to FILL.
- FILL: one cycle with cache_en=1, cache_ld=1, cache_addr=latched addr, cache_blkin=fill buffer. Next state is LOOKUP (replay, which is guaranteed to hit).
- RESP: cpu_done=1 for one cycle; next state is IDLE. A new request is accepted no earlier than the following cycle.
- Latency from accept edge to cpu_done:
  - Hit: 2 cycles.
  - Clean miss: 5 + mem wait cycles.
  - Dirty miss: additionally the WB wait plus 1 cycle.
- mem_ack outside WB/FETCH is ignored. cache_miss is informational only; cache_hit drives all decisions.
- Reset mid-operation: the FSM aborts and mem_req drops asynchronously. The outstanding memory transfer is abandoned; the memory side must tolerate this. A partial fill is never loaded into the cache.

Optional Feature:
- Macro DCACHE_PERF_CNT_EN.
- When defined: adds outputs perf_hits, perf_misses, perf_wbs, each 32-bit and wrapping.
  - Counts occur only on the first LOOKUP of an access; replays are not counted.
  - Counters reset to 0.
- When undefined: no counter ports or logic; all other behaviour is identical.

Decomposition:
- Package dcache_pkg: state enum (IDLE, LOOKUP, WB, FETCH, FILL, RESP); shared localparams OFFSET_BITS, INDEX_BITS, TAG_BITS, BLOCK_W; a line-address helper function {tag, index, zero offset}.
- Sub-module dcache_mem_port: holds mem_req/mem_we/mem_addr/mem_wdata, performs the ack capture, and enforces the drop-after-ack rule.

Test Plan:
- Read miss, empty cache, addr 0x0000_1234; mem_ack after 3 cycles with word 4 of mem_rdata = 0xDEADBEEF -> mem_we=0, mem_addr=0x1230, one cache_ld pulse, cpu_done with cpu_rdata=0xDEADBEEF.
- Repeat read of 0x1234 -> cpu_done 2 cycles after accept, mem_req stays 0.
- Write 0xCAFEF00D to 0x1234 (hit), then read 0x2234 (same index 0x23) -> WB first with mem_we=1, mem_addr=0x1230, mem_wdata word 4 = 0xCAFEF00D; then FETCH with mem_addr=0x2230; then cpu_done.
- mem_ack delayed 10 cycles -> mem_req, mem_addr and mem_wdata stable throughout, cpu_busy=1, no cpu_done.
- Assert rst during FETCH -> mem_req, cpu_busy and cpu_done go 0 immediately; no cache_ld; the next read of 0x1234 completes normally.
- cpu_req with cpu_rd=cpu_wr=1 -> stays IDLE, cpu_busy=0, no cache strobes, no cpu_done.
